// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush generation for the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers. Handles load-use, branch redirect, imem/dmem wait and
// the sticky halt (normal halt or data-memory timeout).
// Optional feature macro: HAZARD_PERF_EN (builds stall/flush perf counters).
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_reg1_sel,
    input  logic [2:0]  id_reg2_sel,
    input  logic        id_rs_valid,
    input  logic        id_rt_valid,
    input  logic [2:0]  ex_write_reg,
    input  logic        ex_regWrite,
    input  logic        ex_memEn,
    input  logic        ex_memWrite,
    input  logic        ex_branch_taken,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic        mem_halt,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_flush,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] wcnt_nxt;
    logic             err_nxt;
    logic             load_use_c;
    logic             branch_fire_c;

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use_c = ex_memEn & ~ex_memWrite & ex_regWrite &
                        ((id_rs_valid & (id_reg1_sel == ex_write_reg)) |
                         (id_rt_valid & (id_reg2_sel == ex_write_reg)));

    // State, wait counter and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            wcnt   <= '0;
            err    <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            err    <= err_nxt;
            halted <= (state_nxt == HALTED);
        end
    end

    // Next state plus prioritised stall/flush decode.
    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        err_nxt       = err;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_flush  = 1'b0;
        branch_fire_c = 1'b0;

        case (state)
            RUN: begin
                if (dmem_stall) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = CNT_W'(1);
                end else if (mem_halt) begin
                    state_nxt = HALTED;
                end
            end
            MEM_WAIT: begin
                if (dmem_stall) begin
                    if (wcnt >= TIMEOUT) begin
                        state_nxt = HALTED;
                        err_nxt   = 1'b1;
                    end else begin
                        wcnt_nxt = CNT_W'(wcnt + CNT_W'(1));
                    end
                end else begin
                    wcnt_nxt  = '0;
                    // A halt that arrived during the wait is honoured now.
                    state_nxt = mem_halt ? HALTED : RUN;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase

        if (rst) begin
            if (state == HALTED) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_stall = 1'b1;
            end else if (dmem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                branch_fire_c = 1'b1;
            end else if (load_use_c) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (imem_stall) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (state != HALTED) && (stall_cycles != '1)) begin
                stall_cycles <= CNT_W'(stall_cycles + CNT_W'(1));
            end
            if (branch_fire_c && (flush_events != '1)) begin
                flush_events <= CNT_W'(flush_events + CNT_W'(1));
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
